// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: producer/consumer handshake bundle for sync_fifo_param
interface sync_fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic              clr_err_i;
    logic [DATA_W-1:0] data_in_i;
    logic              write_enable_i;
    logic              read_enable_i;
    logic [DATA_W-1:0] data_out_o;
    logic              full_o;
    logic              empty_o;
    logic              almost_full_o;
    logic              almost_empty_o;
    logic [CW-1:0]     count_o;
    logic              overflow_o;
    logic              underflow_o;
    modport master (
        output clr_err_i, data_in_i, write_enable_i, read_enable_i,
        input  data_out_o, full_o, empty_o, almost_full_o, almost_empty_o, count_o, overflow_o, underflow_o
    );
    modport slave (
        input  clr_err_i, data_in_i, write_enable_i, read_enable_i,
        output data_out_o, full_o, empty_o, almost_full_o, almost_empty_o, count_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with registered or FWFT read and sticky error flags
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 256,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = 0
) (
    input logic              clk,
    input logic              rst,
    sync_fifo_param_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_params
        $fatal(1, "sync_fifo_param: illegal DEPTH/AF_LEVEL/AE_LEVEL");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              full, empty, wr_ok, rd_ok;

    always_comb begin
        full     = count_q == DEPTH_C;
        empty    = count_q == '0;
        wr_ok    = bus.write_enable_i && !full;
        rd_ok    = bus.read_enable_i && !empty;
        wr_ptr_d = wr_ptr_q + AW'(wr_ok);
        rd_ptr_d = rd_ptr_q + AW'(rd_ok);
        count_d  = count_q + CW'(wr_ok) - CW'(rd_ok);
        data_d   = rd_ok ? mem[rd_ptr_q] : data_q;
        // a new error in the same cycle as clr_err keeps the flag set
        ovf_d    = (bus.write_enable_i && full) || (ovf_q && !bus.clr_err_i);
        unf_d    = (bus.read_enable_i && empty) || (unf_q && !bus.clr_err_i);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr_q] <= bus.data_in_i;
    end

    // in FWFT mode data_q only shows while empty, holding the last word read
    assign bus.data_out_o     = (FWFT != 0 && !empty) ? mem[rd_ptr_q] : data_q;
    assign bus.full_o         = full;
    assign bus.empty_o        = empty;
    assign bus.almost_full_o  = count_q >= AF_C;
    assign bus.almost_empty_o = count_q <= AE_C;
    assign bus.count_o        = count_q;
    assign bus.overflow_o     = ovf_q;
    assign bus.underflow_o    = unf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed vector bench for sync_fifo_param (DEPTH=8, AF=6, AE=1)
module tb_sync_fifo_param;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_W(8), .DEPTH(8)) b0 ();
    sync_fifo_param_if #(.DATA_W(8), .DEPTH(8)) b1 ();

    sync_fifo_param #(.DATA_W(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(0)) dut (
        .clk(clk), .rst(rst), .bus(b0.slave)
    );
    sync_fifo_param #(.DATA_W(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1)) dut_f (
        .clk(clk), .rst(rst), .bus(b1.slave)
    );

    typedef struct {
        logic       we, re, clr;
        logic [7:0] din;
        int         cnt;
        logic [7:0] dout;
        logic       ovf, unf;
    } vec_t;
    vec_t vq[$];

    function automatic void add(logic we, logic re, logic clr, logic [7:0] din, int cnt, logic [7:0] dout, logic ovf, logic unf);
        vec_t v;
        v = '{we, re, clr, din, cnt, dout, ovf, unf};
        vq.push_back(v);
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_b0(string tag, int cnt, logic [7:0] dout, logic ovf, logic unf);
        check({tag, " count"}, 32'(b0.count_o), 32'(cnt));
        check({tag, " full"}, 32'(b0.full_o), 32'(cnt == 8));
        check({tag, " empty"}, 32'(b0.empty_o), 32'(cnt == 0));
        check({tag, " almost_full"}, 32'(b0.almost_full_o), 32'(cnt >= 6));
        check({tag, " almost_empty"}, 32'(b0.almost_empty_o), 32'(cnt <= 1));
        check({tag, " data_out"}, 32'(b0.data_out_o), 32'(dout));
        check({tag, " overflow"}, 32'(b0.overflow_o), 32'(ovf));
        check({tag, " underflow"}, 32'(b0.underflow_o), 32'(unf));
    endtask

    task automatic drive0(logic we, logic re, logic clr, logic [7:0] din);
        @(negedge clk);
        b0.write_enable_i = we;
        b0.read_enable_i  = re;
        b0.clr_err_i      = clr;
        b0.data_in_i      = din;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // test 2: fill, overflow, drain
        for (int i = 0; i < 8; i++) add(1, 0, 0, 8'(8'h10 + i), i + 1, 8'h00, 0, 0);
        add(1, 0, 0, 8'hAA, 8, 8'h00, 1, 0);
        for (int i = 0; i < 8; i++) add(0, 1, 0, 8'h00, 7 - i, 8'(8'h10 + i), 1, 0);
        add(0, 0, 1, 8'h00, 0, 8'h17, 0, 0);
        // test 3: pointer wrap
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 5; i++) add(1, 0, 0, 8'(8'h40 + 16 * r + i), i + 1, (r == 0) ? 8'h17 : 8'h44, 0, 0);
            for (int i = 0; i < 5; i++) add(0, 1, 0, 8'h00, 4 - i, 8'(8'h40 + 16 * r + i), 0, 0);
        end
        for (int i = 0; i < 8; i++) add(1, 0, 0, 8'(8'h20 + i), i + 1, 8'h54, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 1, 0, 8'h00, 7 - i, 8'(8'h20 + i), 0, 0);
        // test 4: simultaneous read/write, underflow, clear
        for (int i = 0; i < 3; i++) add(1, 0, 0, 8'(8'h60 + i), i + 1, 8'h27, 0, 0);
        for (int k = 0; k < 10; k++) add(1, 1, 0, 8'(8'h63 + k), 3, 8'(8'h60 + k), 0, 0);
        for (int k = 0; k < 3; k++) add(0, 1, 0, 8'h00, 2 - k, 8'(8'h6A + k), 0, 0);
        add(1, 1, 0, 8'h33, 1, 8'h6C, 0, 1);
        add(0, 0, 1, 8'h00, 1, 8'h6C, 0, 0);
        add(0, 1, 0, 8'h00, 0, 8'h33, 0, 0);
        add(0, 1, 1, 8'h00, 0, 8'h33, 0, 1);
        add(0, 0, 1, 8'h00, 0, 8'h33, 0, 0);

        // test 1: reset held with random inputs
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            b0.write_enable_i = 1'($urandom);
            b0.read_enable_i  = 1'($urandom);
            b0.clr_err_i      = 1'($urandom);
            b0.data_in_i      = 8'($urandom);
            b1.write_enable_i = 1'($urandom);
            b1.read_enable_i  = 1'($urandom);
            b1.clr_err_i      = 1'($urandom);
            b1.data_in_i      = 8'($urandom);
            @(posedge clk);
            #1;
            check_b0($sformatf("reset%0d", c), 0, 8'h00, 0, 0);
            check("reset fwft empty", 32'(b1.empty_o), 32'd1);
            check("reset fwft data_out", 32'(b1.data_out_o), 32'h0);
        end
        @(negedge clk);
        {b0.write_enable_i, b0.read_enable_i, b0.clr_err_i, b0.data_in_i} = '0;
        {b1.write_enable_i, b1.read_enable_i, b1.clr_err_i, b1.data_in_i} = '0;
        rst = 1'b1;

        // test 5: FWFT instance
        @(negedge clk);
        b1.write_enable_i = 1'b1;
        b1.data_in_i      = 8'h5A;
        @(posedge clk);
        #1;
        check("fwft write empty", 32'(b1.empty_o), 32'd0);
        check("fwft write data_out", 32'(b1.data_out_o), 32'h5A);
        check("fwft write count", 32'(b1.count_o), 32'd1);
        @(negedge clk);
        b1.write_enable_i = 1'b0;
        b1.read_enable_i  = 1'b1;
        @(posedge clk);
        #1;
        check("fwft read empty", 32'(b1.empty_o), 32'd1);
        check("fwft read data_out", 32'(b1.data_out_o), 32'h5A);
        @(negedge clk);
        b1.read_enable_i = 1'b0;
        @(posedge clk);
        #1;
        check("fwft hold data_out", 32'(b1.data_out_o), 32'h5A);
        check("fwft hold underflow", 32'(b1.underflow_o), 32'd0);

        // tests 2-4 from the vector table
        for (int i = 0; i < vq.size(); i++) begin
            drive0(vq[i].we, vq[i].re, vq[i].clr, vq[i].din);
            check_b0($sformatf("vec%0d", i), vq[i].cnt, vq[i].dout, vq[i].ovf, vq[i].unf);
        end

        // test 6: asynchronous reset mid-operation
        for (int i = 0; i < 5; i++) drive0(1, 0, 0, 8'(8'h81 + i));
        check_b0("pre-reset", 5, 8'h33, 0, 0);
        @(negedge clk);
        b0.write_enable_i = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_b0("async reset", 0, 8'h00, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        drive0(1, 0, 0, 8'h77);
        check_b0("post-reset write", 1, 8'h00, 0, 0);
        drive0(0, 1, 0, 8'h00);
        check_b0("post-reset read", 0, 8'h77, 0, 0);
        drive0(0, 0, 0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
